fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle 16-bit core, directly upstream of the main control decoder.
- Holds the PC and issues requests to instruction memory, which may insert wait states.
- Presents the fetched instruction, its 3-bit opcode (instr[15:13]) and PC+1 (the jal link value) to decode/control.
- Applies jump/branch redirects fed back from control and the ALU when the current instruction retires.

---
 rtl/fetch_if.sv | 35 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack on one side, decoded
// instruction hand-off to control on the other.
interface fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  // Handshakes: imem_req stays high with imem_addr frozen until a cycle with
  // imem_ack, which delivers imem_rdata. instr_valid stays high with
  // instr/opcode/pc/pc_plus1 frozen until a cycle with instr_ready (retire).
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         opcode;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus1;
  logic               jump;
  logic [12:0]        jump_target;
  logic               branch_taken;
  logic [6:0]         branch_offset;
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus1, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, jump, jump_target, branch_taken, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus1, fetch_err,
    output imem_ack, imem_rdata, instr_ready, jump, jump_target, branch_taken, branch_offset
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request/wait handling, jump/branch redirect at retire.
// Optional fetch timeout with sticky fetch_err is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int              TIMEOUT  = 15
`endif
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.master    bus,
  output logic [1:0] state_dbg
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2, S_ERR = 2'd3} state_e;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2} state_e;
`endif

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    next_pc;

  always_comb begin
    pc_plus1 = pc_q + PC_W'(1);
    if (bus.jump) begin
      next_pc = {pc_plus1[PC_W-1:13], bus.jump_target};
    end else if (bus.branch_taken) begin
      next_pc = pc_plus1 + {{(PC_W-7){bus.branch_offset[6]}}, bus.branch_offset};
    end else begin
      next_pc = pc_plus1;
    end
  end

  // req_q is low in the first FETCH cycle after reset, so an ack that
  // arrives late for an abandoned request is not taken as data.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req_q) begin
          if (bus.imem_ack) begin
            instr_d = bus.imem_rdata;
            req_d   = 1'b0;
            state_d = S_VALID;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          req_d   = 1'b0;
          state_d = S_VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_VALID: begin
        req_d = 1'b0;
        if (bus.instr_ready) begin
          pc_d    = next_pc;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        req_d = 1'b0;
      end
`endif
      default: begin
        req_d   = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[INSTR_W-1 -: 3];
  assign bus.instr_valid = (state_q == S_VALID);
  assign bus.pc          = pc_q;
  assign bus.pc_plus1    = pc_plus1;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err   = (state_q == S_ERR);
`else
  assign bus.fetch_err   = 1'b0;
`endif
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable wait states,
// cycle model of the fetch contract, and directed redirect/wrap/reset/timeout vectors.
module tb_fetch_unit;
`ifdef FETCH_TIMEOUT_EN
  localparam int TIMEOUT = 15;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  fetch_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_unit #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int mem_wait   = 0;
  bit mem_dead   = 0;
  bit inject_ack = 0;
  int wcnt       = 0;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'h0123;
      16'h0001: rom = 16'h2000;
      16'h0002: rom = 16'h4000;
      16'h0003: rom = 16'h6000;
      default:  rom = {a[2:0], a[12:0] ^ 13'h0155};
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (inject_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      inject_ack     = 0;
      wcnt           = 0;
    end else if (bus.imem_req && !mem_dead) begin
      if (wcnt >= mem_wait) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rom(bus.imem_addr);
        wcnt           = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        wcnt++;
      end
    end else if (!bus.imem_req) begin
      bus.imem_ack   = ($urandom_range(0, 3) == 0);
      bus.imem_rdata = 16'($urandom);
      wcnt           = 0;
    end else begin
      bus.imem_ack = 1'b0;
    end
  end

  // ---------------- behavioural model + compare ----------------
  bit          m_known = 0;
  bit          m_req, m_valid, m_err;
  logic [15:0] m_pc, m_instr;
  int          m_wcnt;

  function automatic logic [15:0] model_next(input logic [15:0] p, input logic j,
                                             input logic [12:0] jt, input logic b,
                                             input logic [6:0] bo);
    logic [15:0] p1;
    int          off;
    p1  = p + 16'd1;
    off = (bo >= 7'd64) ? int'(bo) - 128 : int'(bo);
    if (j)      model_next = (p1 & 16'hE000) | {3'b000, jt};
    else if (b) model_next = 16'(int'(p1) + off);
    else        model_next = p1;
  endfunction

  always @(negedge clk) begin
    if (m_known) begin
      check("imem_req", bus.imem_req, m_req);
      check("instr_valid", bus.instr_valid, m_valid);
      check("fetch_err", bus.fetch_err, m_err);
      if (m_req) check("imem_addr", bus.imem_addr, m_pc);
      if (m_valid) begin
        check("pc", bus.pc, m_pc);
        check("pc_plus1", bus.pc_plus1, 16'(m_pc + 16'd1));
        check("instr", bus.instr, m_instr);
        check("opcode", bus.opcode, m_instr[15:13]);
      end
    end
    if (reset) begin
      m_known = 1; m_req = 0; m_valid = 0; m_err = 0;
      m_pc = 16'h0000; m_instr = 16'h0000; m_wcnt = 0;
    end else if (m_known && !m_err) begin
      if (m_valid) begin
        if (bus.instr_ready) begin
          m_pc    = model_next(m_pc, bus.jump, bus.jump_target, bus.branch_taken, bus.branch_offset);
          m_valid = 0; m_req = 1; m_wcnt = 0;
        end
      end else if (m_req) begin
        if (bus.imem_ack) begin
          m_instr = bus.imem_rdata; m_valid = 1; m_req = 0;
        end else begin
          m_wcnt++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wcnt == TIMEOUT + 1) begin m_err = 1; m_req = 0; end
`endif
        end
      end else begin
        m_req = 1; m_wcnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [2:0]  op_seen;
  logic [15:0] p1_seen;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_fetch(input logic [15:0] addr);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.imem_req) found = 1;
      else step();
    end
    if (found) check("fetch_addr", bus.imem_addr, addr);
    else begin
      checks++; errors++;
      $display("FAIL fetch_timeout actual=no_req required=req addr=%0h", addr);
    end
  endtask

  task automatic do_retire(input logic j, input logic [12:0] jt, input logic b, input logic [6:0] bo);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.instr_valid) seen = 1;
      else begin
        bus.jump          = 1'($urandom_range(0, 1));
        bus.jump_target   = 13'($urandom);
        bus.branch_taken  = 1'($urandom_range(0, 1));
        bus.branch_offset = 7'($urandom);
        bus.instr_ready   = 1'($urandom_range(0, 1));
        step();
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
    op_seen = bus.opcode;
    p1_seen = bus.pc_plus1;
    bus.jump = j; bus.jump_target = jt; bus.branch_taken = b; bus.branch_offset = bo;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int n;

  initial begin
    reset = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.jump = 1'b0; bus.jump_target = '0; bus.branch_taken = 1'b0; bus.branch_offset = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_instr", bus.instr, 16'h0000);
    check("rst_err", bus.fetch_err, 0);

    // Sequential ROM walk, zero-wait memory
    for (int i = 0; i < 4; i++) begin
      expect_fetch(16'(i));
      do_retire(1'b0, '0, 1'b0, '0);
      check("rom_opcode", op_seen, 3'(i));
      check("rom_pc_plus1", p1_seen, 16'(i + 1));
    end

    // Jump redirects (target keeps pc_plus1[15:13])
    do_retire(1'b1, 13'h1FFF, 1'b0, '0);       expect_fetch(16'h1FFF);
    do_retire(1'b1, 13'h0005, 1'b0, '0);       expect_fetch(16'h2005);
    do_retire(1'b1, 13'h0ABC, 1'b0, '0);       expect_fetch(16'h2ABC);
    do_retire(1'b1, 13'h0005, 1'b0, '0);       expect_fetch(16'h2005);
    do_retire(1'b1, 13'h0ABC, 1'b1, 7'h05);    expect_fetch(16'h2ABC);

    // Reset while in WAIT, stale ack in the following cycle
    mem_wait = 8;
    do_retire(1'b0, '0, 1'b0, '0);
    step(); step();
    reset = 1'b1;
    @(negedge clk) inject_ack = 1;
    step();
    reset = 1'b0;
    check("rstw_req", bus.imem_req, 0);
    check("rstw_valid", bus.instr_valid, 0);
    check("rstw_pc", bus.pc, 16'h0000);
    mem_wait = 0;
    step();
    check("rstw_valid2", bus.instr_valid, 0);
    expect_fetch(16'h0000);

    // Branch redirects
    do_retire(1'b1, 13'h0010, 1'b0, '0);       expect_fetch(16'h0010);
    do_retire(1'b0, '0, 1'b1, 7'h7C);          expect_fetch(16'h000D);
    do_retire(1'b0, '0, 1'b1, 7'h02);          expect_fetch(16'h0010);
    do_retire(1'b0, '0, 1'b1, 7'h05);          expect_fetch(16'h0016);

    // Three wait states, then four cycles of downstream stall
    mem_wait = 3;
    do_retire(1'b0, '0, 1'b0, '0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.instr_valid) break;
      if (bus.imem_req) begin n++; check("wait_addr", bus.imem_addr, 16'h0017); end
      step();
    end
    check("wait_req_cycles", n, 4);
    for (int k = 0; k < 4; k++) begin
      check("hold_valid", bus.instr_valid, 1);
      check("hold_req", bus.imem_req, 0);
      check("hold_pc", bus.pc, 16'h0017);
      check("hold_instr", bus.instr, rom(16'h0017));
      step();
    end
    mem_wait = 0;
    do_retire(1'b0, '0, 1'b0, '0);             expect_fetch(16'h0018);

    // Wrap: negative branch below zero, then sequential past 0xFFFF
    do_retire(1'b0, '0, 1'b1, 7'h66);          expect_fetch(16'hFFFF);
    do_retire(1'b0, '0, 1'b0, '0);             expect_fetch(16'h0000);
    check("wrap_pc_plus1", p1_seen, 16'h0000);

    // Memory stops answering
    step();
    @(negedge clk) mem_dead = 1;
    do_retire(1'b0, '0, 1'b0, '0);
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.imem_req) break;
      n++;
      step();
    end
    check("timeout_req_cycles", n, TIMEOUT + 1);
    for (int k = 0; k < 5; k++) begin
      check("err_sticky", bus.fetch_err, 1);
      check("err_req", bus.imem_req, 0);
      check("err_valid", bus.instr_valid, 0);
      step();
    end
`else
    for (int k = 0; k < 30; k++) begin
      check("dead_req", bus.imem_req, 1);
      check("dead_err", bus.fetch_err, 0);
      check("dead_addr", bus.imem_addr, 16'h0001);
      step();
    end
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_dead = 0;
    check("final_err", bus.fetch_err, 0);
    check("final_pc", bus.pc, 16'h0000);
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
